algo_2r1w_t1_mem_rsp: RTL and testbench



---
 rtl/algo_2r1w_t1_mem_rsp.sv | 147 ++++++++++++++
 tb/tb_algo_2r1w_t1_mem_rsp.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/algo_2r1w_t1_mem_rsp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | algo_2r1w_t1_mem_rsp : 2R1W t1 memory responder with init sweep/err flag |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module algo_2r1w_t1_mem_rsp #(
  parameter int WIDTH       = 15,
  parameter int NUMADDR     = 256,
  parameter int BITADDR     = 8,
  parameter int T1_DELAY    = 2,
  parameter bit RDWR_BYPASS = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               t1_writeA,
  input  logic [BITADDR-1:0] t1_addrA,
  input  logic [WIDTH-1:0]   t1_dinA,
  input  logic [WIDTH-1:0]   t1_bwA,
  input  logic               t1_readB,
  input  logic [BITADDR-1:0] t1_addrB,
  output logic [WIDTH-1:0]   t1_doutB,
  output logic               t1_vldB,
  input  logic               t1_readC,
  input  logic [BITADDR-1:0] t1_addrC,
  output logic [WIDTH-1:0]   t1_doutC,
  output logic               t1_vldC,
  output logic               ready,
  output logic               t1_err
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [BITADDR-1:0] C_LAST = BITADDR'(NUMADDR - 1);

  logic [0:0]          state_q, state_d;
  logic [BITADDR-1:0]  cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [T1_DELAY-1:0] vld_q [2];
  logic [T1_DELAY-1:0] vld_d [2];
  logic [WIDTH-1:0]    dat_q [2][T1_DELAY];
  logic [WIDTH-1:0]    dat_d [2][T1_DELAY];
  logic [WIDTH-1:0]    mem_q [NUMADDR];

  logic                rdy;
  logic                wr_x;
  logic                wr_inr;
  logic                wr_ok;
  logic [WIDTH-1:0]    merged;
  logic                mem_we;
  logic [BITADDR-1:0]  mem_waddr;
  logic [WIDTH-1:0]    mem_wdata;
  logic [1:0]          rd_req;
  logic [1:0]          rd_x;
  logic [1:0]          rd_inr;
  logic [BITADDR-1:0]  rd_addr [2];
  logic [WIDTH-1:0]    rd_data [2];

  function automatic logic in_range(input logic [BITADDR-1:0] a);
    return {{(32-BITADDR){1'b0}}, a} < 32'(NUMADDR);
  endfunction

  assign rdy        = (state_q == ST_RUN);
  assign rd_addr[0] = t1_addrB;
  assign rd_addr[1] = t1_addrC;

  always_comb begin
    wr_x      = $isunknown({t1_writeA, t1_addrA});
    rd_x[0]   = $isunknown({t1_readB, t1_addrB});
    rd_x[1]   = $isunknown({t1_readC, t1_addrC});
    rd_req    = {t1_readC, t1_readB} | rd_x;
    wr_inr    = in_range(t1_addrA);
    rd_inr[0] = in_range(t1_addrB);
    rd_inr[1] = in_range(t1_addrC);
    wr_ok     = rdy && t1_writeA && wr_inr && !wr_x;
    merged    = (mem_q[t1_addrA] & ~t1_bwA) | (t1_dinA & t1_bwA);

    // Reads see the array before this cycle's write unless bypass is enabled.
    for (int p = 0; p < 2; p++) begin
      if (!rd_inr[p] || rd_x[p])
        rd_data[p] = '0;
      else if (RDWR_BYPASS && wr_ok && (t1_addrA == rd_addr[p]))
        rd_data[p] = merged;
      else
        rd_data[p] = mem_q[rd_addr[p]];
    end

    err_d = (!rdy && (t1_writeA || t1_readB || t1_readC)) ||
            (rdy && (wr_x || (rd_x != 2'b00) ||
                     (t1_writeA && !wr_inr) ||
                     (t1_readB && !rd_inr[0]) ||
                     (t1_readC && !rd_inr[1])));

    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = wr_ok;
    mem_waddr = t1_addrA;
    mem_wdata = merged;
    if (state_q == ST_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = '0;
      cnt_d     = cnt_q + 1'b1;
      if (cnt_q == C_LAST) state_d = ST_RUN;
    end

    // Last data stage only loads with a strobe so dout holds between reads.
    for (int p = 0; p < 2; p++) begin
      vld_d[p]    = T1_DELAY'({vld_q[p], rdy && rd_req[p]});
      dat_d[p][0] = rd_data[p];
      for (int k = 1; k < T1_DELAY; k++) dat_d[p][k] = dat_q[p][k-1];
      if (!vld_d[p][T1_DELAY-1]) dat_d[p][T1_DELAY-1] = dat_q[p][T1_DELAY-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      for (int p = 0; p < 2; p++) begin
        vld_q[p] <= '0;
        for (int k = 0; k < T1_DELAY; k++) dat_q[p][k] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      for (int p = 0; p < 2; p++) begin
        vld_q[p] <= vld_d[p];
        for (int k = 0; k < T1_DELAY; k++) dat_q[p][k] <= dat_d[p][k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign ready    = rdy;
  assign t1_err   = err_q;
  assign t1_vldB  = vld_q[0][T1_DELAY-1];
  assign t1_doutB = dat_q[0][T1_DELAY-1];
  assign t1_vldC  = vld_q[1][T1_DELAY-1];
  assign t1_doutC = dat_q[1][T1_DELAY-1];

endmodule
`default_nettype wire

// File: tb/tb_algo_2r1w_t1_mem_rsp.sv
`default_nettype none
// Scoreboard bench for algo_2r1w_t1_mem_rsp: randomized and directed traffic
// against an array-based reference model of the responder.
module tb_algo_2r1w_t1_mem_rsp;

  localparam int WIDTH   = 15;
  localparam int NUMADDR = 200;
  localparam int BITADDR = 8;
  localparam int DLY     = 2;
  localparam bit BYP     = 1'b0;

  typedef struct {
    int               cyc;
    logic [WIDTH-1:0] d;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic               writeA, readB, readC;
  logic [BITADDR-1:0] addrA, addrB, addrC;
  logic [WIDTH-1:0]   dinA, bwA;
  logic [WIDTH-1:0]   doutB, doutC;
  logic               vldB, vldC, ready, err;

  algo_2r1w_t1_mem_rsp #(
    .WIDTH(WIDTH), .NUMADDR(NUMADDR), .BITADDR(BITADDR),
    .T1_DELAY(DLY), .RDWR_BYPASS(BYP)
  ) dut (
    .clk(clk), .rst(rst),
    .t1_writeA(writeA), .t1_addrA(addrA), .t1_dinA(dinA), .t1_bwA(bwA),
    .t1_readB(readB), .t1_addrB(addrB), .t1_doutB(doutB), .t1_vldB(vldB),
    .t1_readC(readC), .t1_addrC(addrC), .t1_doutC(doutC), .t1_vldC(vldC),
    .ready(ready), .t1_err(err)
  );

  always #5 clk = ~clk;

  int               cyc = 0;
  int               rdy_cyc = 1 << 30;
  int               checks = 0;
  int               errors = 0;
  rsp_t             q [2][$];
  logic [WIDTH-1:0] last [2];
  logic [WIDTH-1:0] mem_m [NUMADDR];
  bit               err_exp [int];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic mon(input int p, input logic v, input logic [WIDTH-1:0] d);
    rsp_t r;
    string nm = (p == 0) ? "B" : "C";
    if (v === 1'b1) begin
      if (q[p].size() == 0) begin
        chk({"vld", nm, "_unexpected"}, 32'(v), 32'd0);
      end else begin
        r = q[p].pop_front();
        chk({"latency", nm}, 32'(cyc), 32'(r.cyc));
        chk({"dout", nm}, 32'(d), 32'(r.d));
        last[p] = r.d;
      end
    end else begin
      chk({"vld", nm, "_level"}, 32'(v), 32'd0);
      chk({"hold", nm}, 32'(d), 32'(last[p]));
      if (q[p].size() > 0 && q[p][0].cyc <= cyc) begin
        r = q[p].pop_front();
        chk({"missing_vld", nm}, 32'(v), 32'd1);
      end
    end
  endtask

  always @(negedge clk) begin
    chk("ready", 32'(ready), 32'(!rst && cyc >= rdy_cyc));
    chk("t1_err", 32'(err), 32'(err_exp.exists(cyc) && err_exp[cyc]));
    mon(0, vldB, doutB);
    mon(1, vldC, doutC);
  end

  // One request cycle: drive, update the model, schedule expected responses.
  task automatic req(input bit w, input int aa, input logic [WIDTH-1:0] din,
                     input logic [WIDTH-1:0] bw, input bit rb, input int ab,
                     input bit rc, input int ac);
    int               n = cyc;
    bit               e = 1'b0;
    logic [WIDTH-1:0] mg;
    writeA = w;  addrA = BITADDR'(aa); dinA = din; bwA = bw;
    readB  = rb; addrB = BITADDR'(ab);
    readC  = rc; addrC = BITADDR'(ac);
    if (n < rdy_cyc) begin
      if (w || rb || rc) err_exp[n+1] = 1'b1;
    end else begin
      mg = (aa < NUMADDR) ? ((mem_m[aa] & ~bw) | (din & bw)) : '0;
      if (rb) begin
        if (ab >= NUMADDR) begin e = 1'b1; q[0].push_back('{n + DLY, '0}); end
        else q[0].push_back('{n + DLY, (BYP && w && aa == ab) ? mg : mem_m[ab]});
      end
      if (rc) begin
        if (ac >= NUMADDR) begin e = 1'b1; q[1].push_back('{n + DLY, '0}); end
        else q[1].push_back('{n + DLY, (BYP && w && aa == ac) ? mg : mem_m[ac]});
      end
      if (w) begin
        if (aa >= NUMADDR) e = 1'b1;
        else mem_m[aa] = mg;
      end
      if (e) err_exp[n+1] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) req(0, 0, '0, '0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input int hold);
    rst = 1'b1;
    rdy_cyc = 1 << 30;
    q[0].delete(); q[1].delete();
    last[0] = '0; last[1] = '0;
    err_exp.delete();
    for (int i = 0; i < NUMADDR; i++) mem_m[i] = '0;
    repeat (hold) @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_cyc = cyc + NUMADDR;
  endtask

  function automatic int raddr();
    return ($urandom_range(7) == 0) ? 200 + $urandom_range(55) : $urandom_range(23);
  endfunction

  initial begin
    writeA = 0; addrA = '0; dinA = '0; bwA = '0;
    readB = 0; addrB = '0; readC = 0; addrC = '0;
    do_reset(3);
    // Abort the init sweep part-way; pre-ready requests only raise t1_err.
    idle(95);
    req(0, 0, '0, '0, 1, 3, 0, 0);
    idle(4);
    do_reset(2);
    idle(50);
    req(1, 7, 15'h1111, 15'h7FFF, 1, 7, 1, 8);
    idle(NUMADDR);
    // Every address reads back zero after the sweep.
    for (int i = 0; i < NUMADDR; i++) req(0, 0, '0, '0, 1, i, 1, NUMADDR - 1 - i);
    idle(3);
    // Masked write sequence on address 5.
    req(1, 5, 15'h7FFF, 15'h7FFF, 0, 0, 0, 0);
    req(1, 5, 15'h0000, 15'h00FF, 0, 0, 0, 0);
    req(0, 0, '0, '0, 1, 5, 0, 0);
    idle(3);
    // Same-address write and dual read.
    req(1, 9, 15'h1234, 15'h7FFF, 1, 9, 1, 9);
    req(0, 0, '0, '0, 1, 9, 1, 9);
    idle(3);
    // Back-to-back reads of a preloaded ramp.
    for (int i = 0; i < 16; i++) req(1, i, WIDTH'(i), 15'h7FFF, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) req(0, 0, '0, '0, 1, i, 0, 0);
    idle(3);
    // Out-of-range write then read.
    req(1, 250, 15'h5555, 15'h7FFF, 0, 0, 0, 0);
    req(0, 0, '0, '0, 1, 250, 1, 250);
    idle(3);
    for (int i = 0; i < 500; i++)
      req($urandom_range(1), raddr(), WIDTH'($urandom), WIDTH'($urandom),
          $urandom_range(1), raddr(), $urandom_range(1), raddr());
    idle(DLY + 3);
    chk("drainB", 32'(q[0].size()), 32'd0);
    chk("drainC", 32'(q[1].size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
